// File: rtl/lsu.sv
// Load/store unit: formats and launches one data-memory transaction per memory instruction.
// Optional REQ timeout is enabled by defining LSU_TIMEOUT_EN.
module lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2_data,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        access_fault,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] load_data_d, addr_d, wdata_d;
  logic [3:0]  wstrb_d;
  logic        req_d, we_d;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            to_fault_q, to_fault_d;
`endif

  logic [1:0]  off;
  logic        fvalid, aligned, legal;
  logic [3:0]  wstrb_fmt;
  logic [31:0] wdata_fmt, ld_fmt;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign off = alu_result[1:0];

  always_comb begin
    fvalid = load ? (funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
                  : (funct3 inside {3'd0, 3'd1, 3'd2});
    case (funct3[1:0])
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~off[0];
      2'd2:    aligned = (off == 2'd0);
      default: aligned = 1'b0;
    endcase
    legal = (load ^ store) & fvalid & aligned;
  end

  always_comb begin
    case (funct3[1:0])
      2'd0: begin
        wdata_fmt = {4{rs2_data[7:0]}};
        wstrb_fmt = 4'b0001 << off;
      end
      2'd1: begin
        wdata_fmt = {2{rs2_data[15:0]}};
        wstrb_fmt = off[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata_fmt = rs2_data;
        wstrb_fmt = 4'b1111;
      end
    endcase
  end

  always_comb begin
    ld_byte = dmem_rdata[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_q)
      3'd0:    ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_fmt = {24'd0, ld_byte};
      3'd5:    ld_fmt = {16'd0, ld_half};
      default: ld_fmt = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    funct3_d    = funct3_q;
    load_data_d = load_data;
    addr_d      = dmem_addr;
    wdata_d     = dmem_wdata;
    wstrb_d     = dmem_wstrb;
    req_d       = dmem_req;
    we_d        = dmem_we;
`ifdef LSU_TIMEOUT_EN
    cnt_d       = cnt_q;
    to_fault_d  = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (legal) begin
          addr_d   = {alu_result[31:2], 2'b00};
          we_d     = store;
          wstrb_d  = store ? wstrb_fmt : 4'b0000;
          wdata_d  = store ? wdata_fmt : 32'd0;
          off_d    = off;
          funct3_d = funct3;
          req_d    = 1'b1;
          state_d  = StReq;
`ifdef LSU_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      StReq: begin
        if (dmem_ready) begin
          req_d   = 1'b0;
          state_d = StDone;
          if (!dmem_we) load_data_d = ld_fmt;
`ifdef LSU_TIMEOUT_EN
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          // Counter would reach the limit this cycle: abandon the access.
          req_d      = 1'b0;
          state_d    = StDone;
          to_fault_d = 1'b1;
          if (!dmem_we) load_data_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      off_q      <= 2'd0;
      funct3_q   <= 3'd0;
      load_data  <= 32'd0;
      dmem_addr  <= 32'd0;
      dmem_wdata <= 32'd0;
      dmem_wstrb <= 4'd0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q      <= '0;
      to_fault_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      off_q      <= off_d;
      funct3_q   <= funct3_d;
      load_data  <= load_data_d;
      dmem_addr  <= addr_d;
      dmem_wdata <= wdata_d;
      dmem_wstrb <= wstrb_d;
      dmem_req   <= req_d;
      dmem_we    <= we_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q      <= cnt_d;
      to_fault_q <= to_fault_d;
`endif
    end
  end

  // Gated by rst so both outputs read 0 while reset is held.
  assign stall = ~rst & (load | store) & legal & (state_q != StDone);
`ifdef LSU_TIMEOUT_EN
  assign access_fault = ~rst & (((state_q == StIdle) & (load | store) & ~legal) | to_fault_q);
`else
  assign access_fault = ~rst & (state_q == StIdle) & (load | store) & ~legal;
`endif

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu; timeout cases run when LSU_TIMEOUT_EN is defined.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0, store = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] alu_result = 32'd0, rs2_data = 32'd0;
  logic [31:0] load_data;
  logic        stall, access_fault;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;

  int errors = 0;
  int checks = 0;

  lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .load(load), .store(store), .funct3(funct3),
    .alu_result(alu_result), .rs2_data(rs2_data), .load_data(load_data), .stall(stall),
    .access_fault(access_fault), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one instruction until stall drops; ready rises on REQ cycle wait_n+1.
  // Returns stall/REQ cycle counts and the bus values seen on the first REQ cycle.
  task automatic access(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                        input int wait_n, output int stall_n, output int req_n,
                        output logic stable, output logic [31:0] a0, output logic [3:0] s0,
                        output logic [31:0] d0, output logic w0);
    logic done;
    load = ld; store = st; funct3 = f3; alu_result = addr; rs2_data = wd;
    dmem_rdata = rd; dmem_ready = 1'b0;
    stall_n = 0; req_n = 0; stable = 1'b1; done = 1'b0;
    a0 = 32'd0; s0 = 4'd0; d0 = 32'd0; w0 = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      #1;
      if (dmem_req) begin
        if (req_n == 0) begin
          a0 = dmem_addr; s0 = dmem_wstrb; d0 = dmem_wdata; w0 = dmem_we;
        end else if (dmem_addr !== a0 || dmem_wstrb !== s0 || dmem_wdata !== d0 ||
                     dmem_we !== w0) begin
          stable = 1'b0;
        end
        req_n++;
        dmem_ready = (req_n > wait_n);
      end else begin
        dmem_ready = 1'b0;
      end
      if (!stall) done = 1'b1;
      else begin
        stall_n++;
        @(posedge clk);
      end
    end
  endtask

  task automatic idle();
    load = 1'b0; store = 1'b0; dmem_ready = 1'b0;
    @(posedge clk);
    #1;
  endtask

  int          sn, rn;
  logic        stb, w0;
  logic [31:0] a0, d0;
  logic [3:0]  s0;

  initial begin
    // Reset with a legal load presented: outputs must still read 0.
    load = 1'b1; funct3 = 3'd2; alu_result = 32'h0;
    #2 rst = 1'b1;
    #1;
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_we", {31'd0, dmem_we}, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wstrb", {28'd0, dmem_wstrb}, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_fault", {31'd0, access_fault}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    load = 1'b0;
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;

    // LB, byte lane 3, negative byte
    access(1'b1, 1'b0, 3'd0, 32'h103, 32'd0, 32'h80FF_1234, 0, sn, rn, stb, a0, s0, d0, w0);
    chk("lb_stall_cycles", sn, 2);
    chk("lb_addr", a0, 32'h100);
    chk("lb_wstrb", {28'd0, s0}, 32'd0);
    chk("lb_we", {31'd0, w0}, 32'd0);
    chk("lb_data", load_data, 32'hFFFF_FF80);
    chk("lb_req_done", {31'd0, dmem_req}, 32'd0);
    idle();

    access(1'b1, 1'b0, 3'd4, 32'h103, 32'd0, 32'h80FF_1234, 0, sn, rn, stb, a0, s0, d0, w0);
    chk("lbu_stall_cycles", sn, 2);
    chk("lbu_data", load_data, 32'h0000_0080);
    idle();

    // SH to upper half; load_data must keep the LBU result
    access(1'b0, 1'b1, 3'd1, 32'h202, 32'h1234_BEEF, 32'hDEAD_DEAD, 0, sn, rn, stb, a0, s0,
           d0, w0);
    chk("sh_we", {31'd0, w0}, 32'd1);
    chk("sh_addr", a0, 32'h200);
    chk("sh_wstrb", {28'd0, s0}, 32'h0000_000C);
    chk("sh_wdata", d0, 32'hBEEF_BEEF);
    chk("sh_load_data_kept", load_data, 32'h0000_0080);
    idle();

    access(1'b0, 1'b1, 3'd0, 32'h301, 32'h0000_00AB, 32'd0, 0, sn, rn, stb, a0, s0, d0, w0);
    chk("sb_wstrb", {28'd0, s0}, 32'h0000_0002);
    chk("sb_wdata", d0, 32'hABAB_ABAB);
    idle();

    access(1'b0, 1'b1, 3'd2, 32'h404, 32'hCAFE_F00D, 32'd0, 0, sn, rn, stb, a0, s0, d0, w0);
    chk("sw_wstrb", {28'd0, s0}, 32'h0000_000F);
    chk("sw_wdata", d0, 32'hCAFE_F00D);
    chk("sw_addr", a0, 32'h404);
    idle();

    access(1'b1, 1'b0, 3'd1, 32'h0, 32'd0, 32'h1234_8001, 0, sn, rn, stb, a0, s0, d0, w0);
    chk("lh_data", load_data, 32'hFFFF_8001);
    idle();

    // Misaligned LW
    access(1'b1, 1'b0, 3'd2, 32'h6, 32'd0, 32'd0, 0, sn, rn, stb, a0, s0, d0, w0);
    chk("mis_fault", {31'd0, access_fault}, 32'd1);
    chk("mis_stall_cycles", sn, 0);
    @(posedge clk); #1;
    chk("mis_no_req", {31'd0, dmem_req}, 32'd0);
    chk("mis_load_data_kept", load_data, 32'hFFFF_8001);
    idle();

    // load and store together
    access(1'b1, 1'b1, 3'd2, 32'h0, 32'd0, 32'd0, 0, sn, rn, stb, a0, s0, d0, w0);
    chk("both_fault", {31'd0, access_fault}, 32'd1);
    chk("both_stall_cycles", sn, 0);
    @(posedge clk); #1;
    chk("both_no_req", {31'd0, dmem_req}, 32'd0);
    idle();

    // LHU with four wait cycles
    access(1'b1, 1'b0, 3'd5, 32'h2, 32'd0, 32'hA55A_0000, 4, sn, rn, stb, a0, s0, d0, w0);
    chk("lhu_stall_cycles", sn, 6);
    chk("lhu_req_cycles", rn, 5);
    chk("lhu_bus_stable", {31'd0, stb}, 32'd1);
    chk("lhu_data", load_data, 32'h0000_A55A);
    chk("lhu_fault", {31'd0, access_fault}, 32'd0);
    idle();

    // Asynchronous reset in the middle of REQ
    load = 1'b1; funct3 = 3'd2; alu_result = 32'h40;
    @(posedge clk); #1;
    chk("mid_req_up", {31'd0, dmem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_req", {31'd0, dmem_req}, 32'd0);
    chk("arst_stall", {31'd0, stall}, 32'd0);
    chk("arst_load_data", load_data, 32'd0);
    load = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    access(1'b1, 1'b0, 3'd2, 32'h40, 32'd0, 32'h1234_5678, 1, sn, rn, stb, a0, s0, d0, w0);
    chk("post_rst_stall_cycles", sn, 3);
    chk("post_rst_data", load_data, 32'h1234_5678);
    idle();

`ifdef LSU_TIMEOUT_EN
    access(1'b1, 1'b0, 3'd2, 32'h10, 32'd0, 32'hFFFF_FFFF, 100, sn, rn, stb, a0, s0, d0, w0);
    chk("to_req_cycles", rn, 4);
    chk("to_stall_cycles", sn, 5);
    chk("to_fault", {31'd0, access_fault}, 32'd1);
    chk("to_data", load_data, 32'd0);
    idle();
    chk("to_fault_pulse", {31'd0, access_fault}, 32'd0);
    chk("to_back_idle_req", {31'd0, dmem_req}, 32'd0);
    // ready on the expiry cycle completes normally
    access(1'b1, 1'b0, 3'd2, 32'h10, 32'd0, 32'h0BAD_F00D, 3, sn, rn, stb, a0, s0, d0, w0);
    chk("to_race_fault", {31'd0, access_fault}, 32'd0);
    chk("to_race_data", load_data, 32'h0BAD_F00D);
    idle();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit directly downstream of the ALU in the single-cycle RISC-V datapath.
- Takes the ALU sum as the effective address and rs2 as store data, and runs a handshaked transaction on the data-memory bus.
- Lane-aligns and sign/zero-extends load data for register writeback.
- Holds `stall` high to freeze the PC and register file until the access completes.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in REQ waiting for `dmem_ready`. Used only when LSU_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- load  in  1  current instruction is a load
- store  in  1  current instruction is a store
- funct3  in  3  RISC-V width/sign field (LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2)
- alu_result  in  32  effective address from the ALU
- rs2_data  in  32  store source register
- load_data  out  32  extended load result, registered
- stall  out  1  freeze core while an access is in progress
- access_fault  out  1  misaligned, illegal or (optionally) timed-out access
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned address (bits [1:0] = 0)
- dmem_wstrb  out  4  byte write enables
- dmem_wdata  out  32  lane-replicated write data
- dmem_ready  in  1  bus accepts/completes the current request
- dmem_rdata  in  32  read word, valid when `dmem_ready` = 1 on a read

Behaviour:
- Reset values (async, any state): state = IDLE, counter = 0, and all of `load_data`, `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wstrb`, `dmem_wdata`, `access_fault` and `stall` are 0.
- Access is legal if exactly one of `load`/`store` is 1, `funct3` is valid for that type, and the address is naturally aligned:
  - halfword: addr[0] = 0
  - word: addr[1:0] = 0
- FSM IDLE:
  - Legal access: register `dmem_addr` = {addr[31:2], 2'b00}, `dmem_we`, `dmem_wstrb`, `dmem_wdata`, the lane offset and `funct3`; set `dmem_req` = 1; go to REQ.
  - Illegal access, or both `load` and `store` high: no bus activity, stay in IDLE, `access_fault` = 1 combinationally this cycle, `stall` = 0, `load_data` unchanged.
- FSM REQ:
  - `dmem_req` = 1 and all bus outputs held stable until `dmem_ready`.
  - On `dmem_ready`: drop `dmem_req`; for a load, capture the formatted `dmem_rdata` into `load_data`; go to DONE.
- FSM DONE: `stall` = 0 so the core retires the instruction; unconditionally go to IDLE.
- `stall` = (`load` | `store`) & legal & state != DONE.
  - Minimum stall is 2 cycles (`dmem_ready` high on the first REQ cycle).
  - Back-to-back memory instructions each start from IDLE.
- Store formatting:
  - SB: wdata = {4{rs2[7:0]}}, wstrb = 1 << off.
  - SH: wdata = {2{rs2[15:0]}}, wstrb = 4'b0011 (off = 0) or 4'b1100 (off = 2).
  - SW: wdata = rs2, wstrb = 4'b1111.
- Load formatting:
  - Byte lane = rdata[8*off+7 : 8*off]; halfword lane = rdata[16*off[1]+15 : 16*off[1]].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Reads drive `dmem_wstrb` = 0.
- `load_data` changes only on load completion; stores never modify it.
- `dmem_ready` outside REQ is ignored.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to REQ and increments each REQ cycle without `dmem_ready`.
  - When it reaches TIMEOUT_CYCLES: drop `dmem_req`, set `load_data` = 0 (loads only), go to DONE, and pulse a registered `access_fault` for the DONE cycle.
  - `dmem_ready` in the same cycle as expiry wins (normal completion).
- Undefined: no counter; REQ waits indefinitely; TIMEOUT_CYCLES unused.

Test Plan:
- LB, addr 0x0000_0103, `dmem_rdata` 0x80FF_1234, ready on first REQ cycle:
  - `dmem_addr` = 0x100, `dmem_wstrb` = 0, `load_data` = 0xFFFF_FF80, `stall` high 2 cycles.
  - Repeat as LBU: `load_data` = 0x0000_0080.
- SH, addr 0x0000_0202, rs2 0x1234_BEEF: `dmem_we` = 1, `dmem_addr` = 0x200, `dmem_wstrb` = 4'b1100, `dmem_wdata` = 0xBEEF_BEEF, `load_data` unchanged.
- LW at 0x0000_0006, and separately `load` = `store` = 1: `access_fault` = 1 same cycle, `dmem_req` never asserts, `stall` = 0.
- LHU at 0x0000_0002 with `dmem_ready` held low 4 REQ cycles, then high on the 5th, rdata 0xA55A_0000:
  - `stall` high exactly 6 cycles, bus outputs stable throughout, `load_data` = 0x0000_A55A.
- `rst` asserted mid-REQ: `dmem_req`, `stall` and `load_data` go to 0 immediately (asynchronously); the next legal load completes normally.
- LSU_TIMEOUT_EN defined, TIMEOUT_CYCLES = 4, LW with `dmem_ready` stuck low: `dmem_req` drops after 4 REQ cycles, `access_fault` pulses 1 cycle, `load_data` = 0, FSM returns to IDLE.
